// File: rtl/sa_output_deskew.sv
// ---------------------------------------------------------------------------
// sa_output_deskew
//
// Output de-skew and drain buffer below a weight-stationary systolic array.
// The bottom PE of column j produces its value for a row j cycles after
// column 0. This block re-aligns those staggered partial sums into whole
// rows, buffers the rows in a small first-word-fall-through FIFO and
// presents them over a valid/ready handshake. The array cannot stall, so
// almost_full gives early warning and overflow flags any dropped row.
//
// Optional feature (compile-time macro DESKEW_RELU_EN):
//   defined   : every ACC_WIDTH lane is clamped to 0 when negative (signed)
//               as the row is written into the FIFO; latency is unchanged.
//   undefined : lanes pass through bit-exact.
//
// Parameters:
//   ARRAY_COLS  number of array columns (>= 2)
//   ACC_WIDTH   partial-sum width per column
//   FIFO_DEPTH  aligned rows buffered (power of two, >= ARRAY_COLS+1)
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of delay line valids, FIFO and overflow
//   col_psum     bottom-row psums, column j at [j*ACC_WIDTH +: ACC_WIDTH]
//   row_valid    column-0 value of a row is valid this cycle
//   row_last     qualifies row_valid, marks the final row of a tile
//   out_data     aligned FIFO head row, same packing as col_psum
//   out_valid    FIFO head valid
//   out_last     row_last carried with the head row
//   out_ready    consumer accepts the head row
//   almost_full  free entries <= ARRAY_COLS
//   fifo_level   occupied entries, 0..FIFO_DEPTH
//   overflow     sticky, a row was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module sa_output_deskew #(
  parameter int ARRAY_COLS = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [ARRAY_COLS*ACC_WIDTH-1:0]   col_psum,
  input  logic                              row_valid,
  input  logic                              row_last,
  output logic [ARRAY_COLS*ACC_WIDTH-1:0]   out_data,
  output logic                              out_valid,
  output logic                              out_last,
  input  logic                              out_ready,
  output logic                              almost_full,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int NS = ARRAY_COLS - 1;
  localparam int RW = ARRAY_COLS * ACC_WIDTH;

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] COLS_L  = LW'(ARRAY_COLS);

  // -------------------------------------------------------------------------
  // Control delay line: row_valid / row_last travel ARRAY_COLS-1 stages so
  // they line up with the live value of the last column.
  // -------------------------------------------------------------------------
  logic [NS-1:0] vld_sr;
  logic [NS-1:0] last_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else if (flush) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= row_valid;
      last_sr[0] <= row_valid & row_last;
      for (int unsigned s = 1; s < NS; s++) begin
        vld_sr[s]  <= vld_sr[s-1];
        last_sr[s] <= last_sr[s-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data de-skew: column j passes through ARRAY_COLS-1-j payload stages, so
  // every lane of a row reaches the FIFO input at the same edge. The last
  // column is taken live. Payload registers carry no reset.
  // -------------------------------------------------------------------------
  logic [RW-1:0] aligned;

  for (genvar j = 0; j < ARRAY_COLS; j++) begin : g_col
    localparam int unsigned DLY = ARRAY_COLS - 1 - j;
    if (DLY == 0) begin : g_live
      assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = col_psum[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] sr [DLY];
      always_ff @(posedge clk) begin
        sr[0] <= col_psum[j*ACC_WIDTH +: ACC_WIDTH];
        for (int unsigned s = 1; s < DLY; s++) begin
          sr[s] <= sr[s-1];
        end
      end
      assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = sr[DLY-1];
    end
  end

  // -------------------------------------------------------------------------
  // Write-side lane conditioning.
  // -------------------------------------------------------------------------
  logic [RW-1:0] wdata;

  always_comb begin
    wdata = aligned;
`ifdef DESKEW_RELU_EN
    for (int unsigned j = 0; j < ARRAY_COLS; j++) begin
      if (aligned[j*ACC_WIDTH + ACC_WIDTH - 1]) begin
        wdata[j*ACC_WIDTH +: ACC_WIDTH] = '0;
      end
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Row FIFO: circular buffer, pointers wrap naturally at the power-of-two
  // depth; a separate level counter distinguishes full from empty.
  // -------------------------------------------------------------------------
  logic [RW-1:0]  mem_data [FIFO_DEPTH];
  logic           mem_last [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic           ovf;

  logic push_req;
  logic full;
  logic pop;
  logic do_push;
  logic drop;

  always_comb begin
    push_req = vld_sr[NS-1];
    full     = (level == DEPTH_L);
    pop      = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a push while full is only
    // dropped when nothing leaves.
    do_push  = push_req & ~flush & (~full | pop);
    drop     = push_req & ~flush & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= wdata;
      mem_last[wr_ptr] <= last_sr[NS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Head payload is gated by out_valid so unreset storage never
  // shows on the outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid   = (level != '0);
    out_data    = out_valid ? mem_data[rd_ptr] : '0;
    out_last    = out_valid ? mem_last[rd_ptr] : 1'b0;
    almost_full = ((DEPTH_L - level) <= COLS_L);
    fifo_level  = level;
    overflow    = ovf;
  end

endmodule

// File: tb/tb_sa_output_deskew.sv
// ---------------------------------------------------------------------------
// tb_sa_output_deskew
//
// Randomized and directed stimulus for sa_output_deskew. Rows are generated
// as whole records; a driver skews each row onto col_psum (column j j cycles
// late). A behavioural model tracks rows in flight by issue time and keeps
// the expected FIFO contents as a queue; a negedge monitor compares the DUT
// head, level, almost_full and overflow against it.
// ---------------------------------------------------------------------------
module tb_sa_output_deskew;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int RW = N * W;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [RW-1:0] col_psum;
  logic          row_valid;
  logic          row_last;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          almost_full;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  always #5 clk = ~clk;

  sa_output_deskew #(
    .ARRAY_COLS (N),
    .ACC_WIDTH  (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .col_psum    (col_psum),
    .row_valid   (row_valid),
    .row_last    (row_last),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .almost_full (almost_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] relu(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    o = r;
`ifdef DESKEW_RELU_EN
    for (int j = 0; j < N; j++) begin
      if ($signed(r[j*W +: W]) < 0) o[j*W +: W] = '0;
    end
`endif
    return o;
  endfunction

  // Row history indexed by the edge at which row_valid was sampled.
  int            edge_no = 0;
  bit            hist_v [64];
  logic [RW-1:0] hist_d [64];

  typedef struct {
    int            e;
    logic [RW-1:0] d;
    logic          l;
  } row_t;

  row_t inflight[$];
  row_t fq[$];
  bit   m_ovf = 1'b0;
  bit   m_pop;
  bit   m_push;
  bit   m_full;
  row_t m_row;

  // Reference model: a row issued at edge k enters the FIFO at edge k+N-1
  // unless a flush or reset happens first.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      inflight.delete();
      fq.delete();
      m_ovf = 1'b0;
    end else begin
      m_pop  = (fq.size() > 0) && out_ready;
      m_full = (fq.size() == D);
      if (row_valid)
        inflight.push_back('{edge_no, relu(hist_d[edge_no % 64]), row_last});
      m_push = 1'b0;
      if (inflight.size() > 0 && inflight[0].e == edge_no - (N - 1)) begin
        m_row  = inflight.pop_front();
        m_push = 1'b1;
      end
      if (m_pop) void'(fq.pop_front());
      if (m_push) begin
        if (m_full && !m_pop) m_ovf = 1'b1;
        else fq.push_back(m_row);
      end
    end
    edge_no++;
  end

  // Monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("level", RW'(fifo_level), RW'(fq.size()));
      chk("overflow", RW'(overflow), RW'(m_ovf));
      chk("almost_full", RW'(almost_full), RW'((D - fq.size()) <= N));
      chk("out_valid", RW'(out_valid), RW'(fq.size() > 0));
      if (out_valid && fq.size() > 0) begin
        chk("out_data", out_data, fq[0].d);
        chk("out_last", RW'(out_last), RW'(fq[0].l));
      end
    end
  end

  task automatic cyc(input bit v, input bit l, input logic [RW-1:0] d,
                     input bit rdy, input bit fl);
    int slot;
    int idx;
    @(negedge clk);
    slot         = edge_no % 64;
    hist_v[slot] = v;
    hist_d[slot] = d;
    row_valid    = v;
    row_last     = v & l;
    out_ready    = rdy;
    flush        = fl;
    for (int j = 0; j < N; j++) begin
      idx = edge_no - j;
      if (idx >= 0 && hist_v[idx % 64]) col_psum[j*W +: W] = hist_d[idx % 64][j*W +: W];
      else col_psum[j*W +: W] = $urandom;
    end
  endtask

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = $urandom;
    return r;
  endfunction

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, rdy, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, RW'(out_valid), '0);
    chk({tag, "_last"}, RW'(out_last), '0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_afull"}, RW'(almost_full), '0);
    chk({tag, "_level"}, RW'(fifo_level), '0);
    chk({tag, "_ovf"}, RW'(overflow), '0);
  endtask

  logic [RW-1:0] r0;

  initial begin
    rst_n = 1'b0; flush = 1'b0; row_valid = 1'b0; row_last = 1'b0;
    out_ready = 1'b0; col_psum = '0;
    idle(3, 1'b0);
    reset_checks("rst");
    @(negedge clk); rst_n = 1'b1;
    idle(2, 1'b1);

    // Single row {1,-2,3,-4}.
    r0 = {32'hFFFF_FFFC, 32'd3, 32'hFFFF_FFFE, 32'd1};
    cyc(1'b1, 1'b1, r0, 1'b1, 1'b0);
    idle(N + 2, 1'b1);

    // Burst of 8 with last on the 8th, consumer always ready.
    for (int i = 0; i < 8; i++) cyc(1'b1, i == 7, rnd_row(), 1'b1, 1'b0);
    idle(N + 2, 1'b1);

    // Nine rows with consumer stalled: ninth is dropped.
    for (int i = 0; i < 9; i++) cyc(1'b1, i == 8, rnd_row(), 1'b0, 1'b0);
    idle(N + 1, 1'b0);
    chk("ovf_after_nine", RW'(overflow), RW'(1));
    chk("level_after_nine", RW'(fifo_level), RW'(D));
    idle(D + 2, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Full FIFO, push and pop in the same cycle.
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, rnd_row(), 1'b0, 1'b0);
    idle(N - 1, 1'b0);
    cyc(1'b1, 1'b1, rnd_row(), 1'b0, 1'b0);
    idle(N - 2, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(2, 1'b0);
    chk("level_push_pop_full", RW'(fifo_level), RW'(D));
    idle(D + 2, 1'b1);

    // Flush with 3 rows in the FIFO and 2 in the delay line.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, rnd_row(), 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(N + 4, 1'b1);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, rnd_row(), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_checks("async_rst");
    idle(2, 1'b1);
    rst_n = 1'b1;
    idle(N + 1, 1'b1);
    cyc(1'b1, 1'b1, rnd_row(), 1'b1, 1'b0);
    idle(N + 2, 1'b1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1, rnd_row(),
          $urandom_range(0, 99) < 50, $urandom_range(0, 99) == 0);
    idle(D + N + 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
